// File: rtl/nib_ram_arbiter_if.sv
// Bundles the two core data-master ports and the RAM slave port of the data RAM arbiter.
// The slave modport is the arbiter's view; the master modport is the cores and the RAM.
interface nib_ram_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req_i, m0_we_i, m0_lock_i, m0_hold_o;
  logic [AW-1:0] m0_addr_i;
  logic [DW-1:0] m0_wdata_i, m0_rdata_o;
  logic          m1_req_i, m1_we_i, m1_lock_i, m1_hold_o;
  logic [AW-1:0] m1_addr_i;
  logic [DW-1:0] m1_wdata_i, m1_rdata_o;
  logic          s_req_o, s_we_o;
  logic [AW-1:0] s_addr_o;
  logic [DW-1:0] s_wdata_o, s_rdata_i;

  modport slave (
    input  m0_req_i, m0_addr_i, m0_we_i, m0_wdata_i, m0_lock_i,
    output m0_rdata_o, m0_hold_o,
    input  m1_req_i, m1_addr_i, m1_we_i, m1_wdata_i, m1_lock_i,
    output m1_rdata_o, m1_hold_o,
    output s_req_o, s_addr_o, s_we_o, s_wdata_o,
    input  s_rdata_i
  );

  modport master (
    output m0_req_i, m0_addr_i, m0_we_i, m0_wdata_i, m0_lock_i,
    input  m0_rdata_o, m0_hold_o,
    output m1_req_i, m1_addr_i, m1_we_i, m1_wdata_i, m1_lock_i,
    input  m1_rdata_o, m1_hold_o,
    input  s_req_o, s_addr_o, s_we_o, s_wdata_o,
    output s_rdata_i
  );
endinterface

// File: rtl/nib_ram_arbiter.sv
// Round-robin two-master arbiter for the single-port data RAM with read-latency tracking and RMW lock.
// Define NIB_ARB_PERF_EN to add saturating stall/grant performance counters.
module nib_ram_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 8
) (
  input  logic             clk,
  input  logic             rstn,
  nib_ram_arbiter_if.slave bus
`ifdef NIB_ARB_PERF_EN
  ,
  output logic [31:0]      m0_stall_cnt_o,
  output logic [31:0]      m1_stall_cnt_o,
  output logic [31:0]      grant_cnt_o
`endif
);
  typedef enum logic {IDLE, RD_WAIT} state_e;

  state_e        state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d, owner_q, owner_d, lock_act_q, lock_act_d;
  logic [1:0]    lat_cnt_q, lat_cnt_d;
  logic [7:0]    lock_cnt_q, lock_cnt_d, lock_nxt;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic [1:0]          req, we, lock, hold;
  logic [1:0][AW-1:0]  addr;
  logic [1:0][DW-1:0]  wdata;
  logic                win, rd_done, s_req, s_we;
  logic [AW-1:0]       s_addr;
  logic [DW-1:0]       s_wdata;

  assign req   = {bus.m1_req_i,   bus.m0_req_i};
  assign we    = {bus.m1_we_i,    bus.m0_we_i};
  assign lock  = {bus.m1_lock_i,  bus.m0_lock_i};
  assign addr  = {bus.m1_addr_i,  bus.m0_addr_i};
  assign wdata = {bus.m1_wdata_i, bus.m0_wdata_i};

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_act_d = lock_act_q;
    lat_cnt_d  = lat_cnt_q;
    lock_cnt_d = lock_cnt_q;
    lock_nxt   = 8'd1;
    win        = rr_ptr_q;
    rd_done    = 1'b0;
    hold       = 2'b00;
    s_req      = 1'b0;
    s_we       = 1'b0;
    s_addr     = '0;
    s_wdata    = '0;
    case (state_q)
      IDLE: if (|req) begin
        // A live lock only gives priority; an idle lock owner does not block the other master.
        if (lock_act_q && req[owner_q]) win = owner_q;
        else if (req == 2'b01)          win = 1'b0;
        else if (req == 2'b10)          win = 1'b1;
        else                            win = rr_ptr_q;
        s_req   = 1'b1;
        s_we    = we[win];
        s_addr  = addr[win];
        s_wdata = wdata[win];
        hold[win ^ 1'b1] = req[win ^ 1'b1];
        hold[win]        = ~we[win];
        owner_d = win;
        if (!we[win]) begin
          state_d   = RD_WAIT;
          lat_cnt_d = 2'(RD_LAT - 1);
        end
        lock_nxt = (lock_act_q && owner_q == win) ? lock_cnt_q + 8'd1 : 8'd1;
        if (lock[win] && lock_nxt != 8'(LOCK_MAX)) begin
          lock_act_d = 1'b1;
          lock_cnt_d = lock_nxt;
        end else begin
          lock_act_d = 1'b0;
          lock_cnt_d = 8'd0;
          rr_ptr_d   = win ^ 1'b1;
        end
      end
      RD_WAIT: begin
        hold = req;
        if (lat_cnt_q == 2'd0) begin
          hold[owner_q] = 1'b0;
          rd_done       = 1'b1;
          state_d       = IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are forced low while reset is asserted, independent of the clock.
    if (!rstn) begin
      s_req   = 1'b0;
      s_we    = 1'b0;
      s_addr  = '0;
      s_wdata = '0;
      hold    = 2'b00;
    end
  end

  assign rdata0_d = (rd_done && !owner_q) ? bus.s_rdata_i : rdata0_q;
  assign rdata1_d = (rd_done &&  owner_q) ? bus.s_rdata_i : rdata1_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= 1'b0;
      owner_q    <= 1'b0;
      lock_act_q <= 1'b0;
      lat_cnt_q  <= 2'd0;
      lock_cnt_q <= 8'd0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_act_q <= lock_act_d;
      lat_cnt_q  <= lat_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign bus.s_req_o    = s_req;
  assign bus.s_we_o     = s_we;
  assign bus.s_addr_o   = s_addr;
  assign bus.s_wdata_o  = s_wdata;
  assign bus.m0_hold_o  = hold[0];
  assign bus.m1_hold_o  = hold[1];
  assign bus.m0_rdata_o = rdata0_d;
  assign bus.m1_rdata_o = rdata1_d;

`ifdef NIB_ARB_PERF_EN
  logic [31:0] st0_q, st0_d, st1_q, st1_d, gnt_q, gnt_d;

  always_comb begin
    st0_d = st0_q;
    st1_d = st1_q;
    gnt_d = gnt_q;
    if (req[0] && hold[0] && st0_q != 32'hFFFF_FFFF) st0_d = st0_q + 32'd1;
    if (req[1] && hold[1] && st1_q != 32'hFFFF_FFFF) st1_d = st1_q + 32'd1;
    if (s_req && gnt_q != 32'hFFFF_FFFF)             gnt_d = gnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st0_q <= '0;
      st1_q <= '0;
      gnt_q <= '0;
    end else begin
      st0_q <= st0_d;
      st1_q <= st1_d;
      gnt_q <= gnt_d;
    end
  end

  assign m0_stall_cnt_o = st0_q;
  assign m1_stall_cnt_o = st1_q;
  assign grant_cnt_o    = gnt_q;
`endif
endmodule

// File: tb/tb_nib_ram_arbiter.sv
// Directed bench for nib_ram_arbiter: per-cycle expectations queued at drive time, checked at negedge.
module tb_nib_ram_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  nib_ram_arbiter_if #(.AW(32), .DW(32)) bus ();

`ifdef NIB_ARB_PERF_EN
  logic [31:0] st0, st1, gnt;
`endif

  nib_ram_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .LOCK_MAX(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef NIB_ARB_PERF_EN
    ,
    .m0_stall_cnt_o (st0),
    .m1_stall_cnt_o (st1),
    .grant_cnt_o    (gnt)
`endif
  );

  // RAM model, one cycle read latency
  logic [31:0] mem [0:255];
  logic [31:0] ram_rdata;
  assign bus.s_rdata_i = ram_rdata;
  always @(posedge clk) begin
    if (bus.s_req_o && bus.s_we_o)  mem[bus.s_addr_o[9:2]] <= bus.s_wdata_o;
    if (bus.s_req_o && !bus.s_we_o) ram_rdata <= mem[bus.s_addr_o[9:2]];
  end

  typedef struct {
    logic [95:0] tag;
    logic [3:0]  ctl;   // {s_req, s_we, m0_hold, m1_hold}
    logic [31:0] addr, wdata, rd0, rd1;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      assert ({bus.s_req_o, bus.s_we_o, bus.m0_hold_o, bus.m1_hold_o} === e.ctl) else begin
        errors++;
        $error("FAIL %0s ctl got %b exp %b", e.tag,
               {bus.s_req_o, bus.s_we_o, bus.m0_hold_o, bus.m1_hold_o}, e.ctl);
      end
      if (e.ctl[3]) begin
        checks++;
        assert ({bus.s_addr_o, bus.s_wdata_o} === {e.addr, e.wdata}) else begin
          errors++;
          $error("FAIL %0s bus got %h/%h exp %h/%h", e.tag, bus.s_addr_o, bus.s_wdata_o, e.addr, e.wdata);
        end
      end
      checks++;
      assert (bus.m0_rdata_o === e.rd0) else begin
        errors++;
        $error("FAIL %0s m0_rdata got %h exp %h", e.tag, bus.m0_rdata_o, e.rd0);
      end
      checks++;
      assert (bus.m1_rdata_o === e.rd1) else begin
        errors++;
        $error("FAIL %0s m1_rdata got %h exp %h", e.tag, bus.m1_rdata_o, e.rd1);
      end
    end
  end

  task automatic m0s(input logic req, we, input logic [31:0] a, d, input logic lk);
    bus.m0_req_i = req; bus.m0_we_i = we; bus.m0_addr_i = a; bus.m0_wdata_i = d; bus.m0_lock_i = lk;
  endtask

  task automatic m1s(input logic req, we, input logic [31:0] a, d, input logic lk);
    bus.m1_req_i = req; bus.m1_we_i = we; bus.m1_addr_i = a; bus.m1_wdata_i = d; bus.m1_lock_i = lk;
  endtask

  // Queue the expectation for the cycle just driven, then advance to the next drive point.
  task automatic cyc(input logic [95:0] tag, input logic [3:0] ctl,
                     input logic [31:0] a, d, r0, r1);
    exp_t e;
    e.tag = tag; e.ctl = ctl; e.addr = a; e.wdata = d; e.rd0 = r0; e.rd1 = r1;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] D1 = 32'h1111_1111;
  localparam logic [31:0] D2 = 32'h2222_2222;

  initial begin
    m0s(1, 1, 32'h44, D1, 0);
    m1s(1, 1, 32'h48, D2, 0);
    @(posedge clk);
    #1;
    cyc("rst",        4'b0000, 0, 0, 0, 0);

    rstn = 1'b1;
    m1s(0, 0, 0, 0, 0);
    m0s(1, 1, 32'h40, DB, 0);
    cyc("wr_m0",      4'b1100, 32'h40, DB, 0, 0);
    m0s(1, 0, 32'h40, 0, 0);
    cyc("rd_m0",      4'b1010, 32'h40, 0, 0, 0);
    cyc("rd_m0_done", 4'b0000, 0, 0, DB, 0);
    m0s(0, 0, 0, 0, 0);
    cyc("idle",       4'b0000, 0, 0, DB, 0);

    m1s(1, 0, 32'h40, 0, 0);
    cyc("rd_m1",      4'b1001, 32'h40, 0, DB, 0);
    rstn = 1'b0;
    m0s(1, 1, 32'h44, D1, 0);
    cyc("rst_mid",    4'b0000, 0, 0, 0, 0);

    rstn = 1'b1;
    m1s(1, 1, 32'h48, D2, 0);
    cyc("both_w0",    4'b1101, 32'h44, D1, 0, 0);
    cyc("both_w1",    4'b1110, 32'h48, D2, 0, 0);
    cyc("both_w2",    4'b1101, 32'h44, D1, 0, 0);
    cyc("both_w3",    4'b1110, 32'h48, D2, 0, 0);

    m0s(0, 0, 0, 0, 0);
    m1s(1, 0, 32'h40, 0, 0);
    cyc("rd_m1_b",    4'b1001, 32'h40, 0, 0, 0);
    m0s(1, 1, 32'h4C, 32'h3333_3333, 0);
    cyc("m0_wait",    4'b0010, 0, 0, 0, DB);
    m1s(0, 0, 0, 0, 0);
    cyc("m0_after",   4'b1100, 32'h4C, 32'h3333_3333, 0, DB);
    m0s(0, 0, 0, 0, 0);
    m1s(1, 1, 32'h50, 32'h4444_4444, 0);
    cyc("m1_alone",   4'b1100, 32'h50, 32'h4444_4444, 0, DB);

    m0s(1, 1, 32'h60, 32'hA0A0_A0A0, 1);
    m1s(1, 1, 32'h64, 32'hB1B1_B1B1, 0);
    for (int i = 0; i < 2; i++) begin
      cyc("lock_m0a", 4'b1101, 32'h60, 32'hA0A0_A0A0, 0, DB);
      cyc("lock_m0b", 4'b1101, 32'h60, 32'hA0A0_A0A0, 0, DB);
      cyc("lock_m1",  4'b1110, 32'h64, 32'hB1B1_B1B1, 0, DB);
    end

    m1s(0, 0, 0, 0, 0);
    m0s(1, 0, 32'h44, 0, 0);
    cyc("rd_m0_44",   4'b1010, 32'h44, 0, 0, DB);
    cyc("rd_m0_44d",  4'b0000, 0, 0, D1, DB);
    m0s(0, 0, 0, 0, 0);
    cyc("tail",       4'b0000, 0, 0, D1, DB);

    checks++;
    assert (sbq.size() == 0) else begin
      errors++;
      $error("FAIL drain queue left %0d exp 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
